// File: rtl/skew_mes_pkg.sv
// Shared types and default constants for the skew measurement path.
// Contents: the strobe responder state encoding, default timing parameters
// and a small helper for sizing counters from several parameters.
package skew_mes_pkg;

  localparam int unsigned DEF_SETTLE_CYCLES = 16;
  localparam int unsigned DEF_STB_WIDTH     = 4;
  localparam int unsigned DEF_SAMPLE_DELAY  = 3;
  localparam int unsigned DEF_N_VOTES       = 5;
  localparam int unsigned DELAY_CODE_W      = 10;
  localparam int unsigned VOTE_W            = 4;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_SETTLE      = 3'd1,
    ST_STROBE      = 3'd2,
    ST_WAIT_SAMPLE = 3'd3,
    ST_ACCUM       = 3'd4,
    ST_DONE        = 3'd5
  } stb_resp_state_t;

  // Largest of three values, used to size a shared phase counter.
  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/cmp_sync.sv
// Two-flop synchroniser for one asynchronous comparator bit.
// Ports: clk_i clock, arstn_i synchronous active-low reset,
//        d asynchronous input, q synchronised output (reset 0).
module cmp_sync (
  input  logic clk_i,
  input  logic arstn_i,
  input  logic d,
  output logic q
);

  logic meta;

  // First flop may go metastable; second flop gives it a cycle to resolve.
  always_ff @(posedge clk_i) begin
    if (!arstn_i) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/cmp_stb_resp.sv
// Strobe responder: per request waits for delay-line settling, fires
// N_VOTES comparator latch strobes, synchronises and majority-votes the
// master/slave comparator outputs, and returns one stb_valid_o pulse.
// Ports: clk_i/arstn_i clock and synchronous active-low reset; en_i run
//        enable; stb_req_i request pulse; delay_code_i applied delay code;
//        m/s_cmp_raw_i asynchronous comparator outputs; cmp_stb_o latch
//        strobe; m/s_cmp_out_o voted decisions; stb_valid_o result pulse;
//        busy_o not idle; req_ovf_o sticky request-while-busy flag.
module cmp_stb_resp
  import skew_mes_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int unsigned STB_WIDTH     = DEF_STB_WIDTH,
  parameter int unsigned SAMPLE_DELAY  = DEF_SAMPLE_DELAY,
  parameter int unsigned N_VOTES       = DEF_N_VOTES
) (
  input  logic                    clk_i,
  input  logic                    arstn_i,
  input  logic                    en_i,
  input  logic                    stb_req_i,
  input  logic [DELAY_CODE_W-1:0] delay_code_i,
  input  logic                    m_cmp_raw_i,
  input  logic                    s_cmp_raw_i,
  output logic                    cmp_stb_o,
  output logic                    m_cmp_out_o,
  output logic                    s_cmp_out_o,
  output logic                    stb_valid_o,
  output logic                    busy_o,
  output logic                    req_ovf_o
);

  // Counter holds (length - 1) and counts down to zero.
  localparam int unsigned CNT_MAX = max3(SETTLE_CYCLES, STB_WIDTH, SAMPLE_DELAY);
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  stb_resp_state_t state_q, state_d;

  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [VOTE_W-1:0]       votes_q, votes_d;
  logic [VOTE_W-1:0]       m_ones_q, m_ones_d;
  logic [VOTE_W-1:0]       s_ones_q, s_ones_d;
  logic [DELAY_CODE_W-1:0] last_code_q, last_code_d;
  logic                    m_out_d, s_out_d, ovf_d;
  logic                    load_settle;
  logic                    m_sync, s_sync;
  logic                    code_chg_c;
  logic                    cnt_zero_c;

  cmp_sync u_m_sync (
    .clk_i   (clk_i),
    .arstn_i (arstn_i),
    .d       (m_cmp_raw_i),
    .q       (m_sync)
  );

  cmp_sync u_s_sync (
    .clk_i   (clk_i),
    .arstn_i (arstn_i),
    .d       (s_cmp_raw_i),
    .q       (s_sync)
  );

  assign code_chg_c = (delay_code_i != last_code_q);
  assign cnt_zero_c = (cnt_q == '0);

  // State, counters and registered outputs.
  always_ff @(posedge clk_i) begin
    if (!arstn_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      votes_q     <= '0;
      m_ones_q    <= '0;
      s_ones_q    <= '0;
      last_code_q <= '0;
      cmp_stb_o   <= 1'b0;
      m_cmp_out_o <= 1'b0;
      s_cmp_out_o <= 1'b0;
      stb_valid_o <= 1'b0;
      busy_o      <= 1'b0;
      req_ovf_o   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      votes_q     <= votes_d;
      m_ones_q    <= m_ones_d;
      s_ones_q    <= s_ones_d;
      last_code_q <= last_code_d;
      // Outputs are decoded from the next state so they line up with it.
      cmp_stb_o   <= (state_d == ST_STROBE);
      stb_valid_o <= (state_d == ST_DONE);
      busy_o      <= (state_d != ST_IDLE);
      m_cmp_out_o <= m_out_d;
      s_cmp_out_o <= s_out_d;
      req_ovf_o   <= ovf_d;
    end
  end

  // Next-state, counter and decision logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    votes_d     = votes_q;
    m_ones_d    = m_ones_q;
    s_ones_d    = s_ones_q;
    last_code_d = last_code_q;
    m_out_d     = m_cmp_out_o;
    s_out_d     = s_cmp_out_o;
    ovf_d       = req_ovf_o | (stb_req_i & (state_q != ST_IDLE));
    load_settle = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (stb_req_i && en_i) load_settle = 1'b1;
      end
      ST_SETTLE: begin
        if (code_chg_c) begin
          load_settle = 1'b1;
        end else if (cnt_zero_c) begin
          state_d = ST_STROBE;
          cnt_d   = CNT_W'(STB_WIDTH - 1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_STROBE: begin
        if (code_chg_c) begin
          load_settle = 1'b1;
        end else if (cnt_zero_c) begin
          state_d = ST_WAIT_SAMPLE;
          cnt_d   = CNT_W'(SAMPLE_DELAY - 1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_WAIT_SAMPLE: begin
        if (code_chg_c) begin
          load_settle = 1'b1;
        end else if (cnt_zero_c) begin
          state_d = ST_ACCUM;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_ACCUM: begin
        if (code_chg_c) begin
          load_settle = 1'b1;
        end else begin
          m_ones_d = m_ones_q + VOTE_W'(m_sync);
          s_ones_d = s_ones_q + VOTE_W'(s_sync);
          votes_d  = votes_q + VOTE_W'(1);
          if (votes_d == VOTE_W'(N_VOTES)) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_STROBE;
            cnt_d   = CNT_W'(STB_WIDTH - 1);
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Fresh settle window: any accumulated votes belong to a stale code.
    if (load_settle) begin
      state_d     = ST_SETTLE;
      cnt_d       = CNT_W'(SETTLE_CYCLES - 1);
      last_code_d = delay_code_i;
      votes_d     = '0;
      m_ones_d    = '0;
      s_ones_d    = '0;
    end

    if (!en_i) state_d = ST_IDLE;

    // Decisions update only together with the stb_valid_o pulse.
    if (state_d == ST_DONE) begin
      m_out_d = (m_ones_d > VOTE_W'(N_VOTES / 2));
      s_out_d = (s_ones_d > VOTE_W'(N_VOTES / 2));
    end
  end

endmodule
